// File: rtl/mask_pipe_reg.sv
// rtl/mask_pipe_reg.sv - masked valid/ready pipeline register with bubble collapse
// Optional skid entry ahead of stage 0 is enabled by defining MASK_PIPE_SKID_EN.
module mask_pipe_reg #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'({16'hFFFF, {240{1'b0}}}),
  parameter logic [WIDTH-1:0] MASK      = WIDTH'({16'hFFFF, {240{1'b0}}})
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+2)-1:0]   occupancy
);

  localparam int OW = $clog2(DEPTH+2);

  // stage DEPTH-1 is the output stage
  logic [DEPTH-1:0] stg_valid;
  logic [DEPTH-1:0] stg_adv;
  logic [DEPTH-1:0] stg_load;
  logic [WIDTH-1:0] stg_data [DEPTH];
  logic [WIDTH-1:0] stg_src  [DEPTH];

  logic             run_en;
  logic             accept;
  logic             stg0_free;
  logic             load0;
  logic [WIDTH-1:0] cap_data;
  logic [WIDTH-1:0] stg0_src;
  logic [OW-1:0]    occ_cnt;

  // in_clear applies the mask to the beat as it is captured
  assign cap_data = in_clear ? (in_data ^ MASK) : in_data;

  // run_en keeps in_ready low for the first cycle after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_en <= 1'b0;
    end else begin
      run_en <= 1'b1;
    end
  end

  // advance chain: a stage moves when downstream is empty or also moving
  always_comb begin
    stg_adv = '0;
    stg_adv[DEPTH-1] = stg_valid[DEPTH-1] & out_ready;
    for (int k = DEPTH-2; k >= 0; k--) begin
      stg_adv[k] = stg_valid[k] & (~stg_valid[k+1] | stg_adv[k+1]);
    end
  end

  assign stg0_free = ~stg_valid[0] | stg_adv[0];

`ifdef MASK_PIPE_SKID_EN
  logic             sk_valid;
  logic [WIDTH-1:0] sk_data;

  // in_ready only depends on the registered skid state (plus flush/startup gating)
  assign in_ready = run_en & ~flush & ~sk_valid;
  assign accept   = in_valid & in_ready;
  // skid beat is always older than a new one, so it has priority into stage 0
  assign load0    = ~flush & stg0_free & (sk_valid | accept);
  assign stg0_src = sk_valid ? sk_data : cap_data;

  // skid entry catches a beat that stage 0 cannot take this cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sk_valid <= 1'b0;
      sk_data  <= RESET_VAL;
    end else if (flush) begin
      sk_valid <= 1'b0;
    end else if (accept && !stg0_free) begin
      sk_valid <= 1'b1;
      sk_data  <= cap_data;
    end else if (sk_valid && stg0_free) begin
      sk_valid <= 1'b0;
    end
  end
`else
  // without a skid entry in_ready follows the advance chain combinationally
  assign in_ready = run_en & ~flush & stg0_free;
  assign accept   = in_valid & in_ready;
  assign load0    = accept;
  assign stg0_src = cap_data;
`endif

  // per-stage load enables; flush suppresses every data move
  always_comb begin
    stg_load = '0;
    stg_load[0] = load0;
    for (int k = 1; k < DEPTH; k++) begin
      stg_load[k] = stg_adv[k-1] & ~flush;
    end
  end

  // per-stage data source: stage 0 from input side, others from upstream stage
  always_comb begin
    stg_src[0] = stg0_src;
    for (int k = 1; k < DEPTH; k++) begin
      stg_src[k] = stg_data[k-1];
    end
  end

  // stage registers: flush clears valids only, data is left in place
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stg_data[k] <= RESET_VAL;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (flush) begin
          stg_valid[k] <= 1'b0;
        end else if (stg_load[k]) begin
          stg_valid[k] <= 1'b1;
        end else if (stg_adv[k]) begin
          stg_valid[k] <= 1'b0;
        end
        if (stg_load[k]) begin
          stg_data[k] <= stg_src[k];
        end
      end
    end
  end

  // occupancy is the population count of all held beats
  always_comb begin
    occ_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_cnt = occ_cnt + OW'(stg_valid[k]);
    end
`ifdef MASK_PIPE_SKID_EN
    occ_cnt = occ_cnt + OW'(sk_valid);
`endif
  end

  assign occupancy = occ_cnt;
  assign out_valid = stg_valid[DEPTH-1];
  assign out_data  = stg_data[DEPTH-1];

endmodule

// File: tb/tb_mask_pipe_reg.sv
// tb/tb_mask_pipe_reg.sv - directed and random checks for mask_pipe_reg
module tb_mask_pipe_reg;

  localparam int W = 256;
  localparam int D = 2;
  localparam logic [W-1:0] RV = {16'hFFFF, 240'h0};
  localparam logic [W-1:0] MK = {16'hFFFF, 240'h0};

  logic         clk;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_clear;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int total;
  int bad;
  int n_acc;
  int n_out;
  logic [W-1:0] q[$];
  logic [W-1:0] exp_d;
  int exp_rdy [5];
  int exp_occ [5];

  mask_pipe_reg #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV), .MASK(MK)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_clear  (in_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0; reset_n = 1; flush = 0; in_valid = 0; in_clear = 0;
    in_data = '0; out_ready = 0; total = 0; bad = 0;
    exp_rdy = '{1, 1, 0, 0, 0};
    exp_occ = '{0, 1, 2, 2, 2};

    // reset state
    #2 reset_n = 0;
    #1;
    chk("rst_data", out_data, RV);
    chk("rst_vld", W'(out_valid), W'(0));
    chk("rst_occ", W'(occupancy), W'(0));
    chk("rst_rdy", W'(in_ready), W'(0));
    step();
    chk("rst_clk_data", out_data, RV);
    reset_n = 1;
    in_valid = 1; in_data = W'(32'h55);
    #1;
    chk("rdy_first", W'(in_ready), W'(0));
    in_valid = 0;
    step();
    chk("rdy_second", W'(in_ready), W'(1));

    // masking with two-cycle latency
    out_ready = 1; in_valid = 1; in_data = W'(16'h1234); in_clear = 1;
    #1;
    chk("mask_rdy", W'(in_ready), W'(1));
    step();
    in_valid = 0; in_clear = 0;
    #1;
    chk("mask_lat1", W'(out_valid), W'(0));
    step();
    chk("mask_vld", W'(out_valid), W'(1));
    chk("mask_data", out_data, {16'hFFFF, 224'h0, 16'h1234});
    step();
    chk("mask_done", W'(out_valid), W'(0));

    // back-to-back streaming of 1..10
    for (int c = 0; c < 12; c++) begin
      if (c < 10) begin
        in_valid = 1; in_data = W'(c + 1);
      end else begin
        in_valid = 0;
      end
      #1;
      if (c < 10) chk("strm_rdy", W'(in_ready), W'(1));
      if (c >= 2) begin
        chk("strm_vld", W'(out_valid), W'(1));
        chk("strm_data", out_data, W'(c - 1));
      end
      if (c >= 2 && c <= 10) chk("strm_occ", W'(occupancy), W'(2));
      step();
    end
    chk("strm_end", W'(out_valid), W'(0));

    // stall to full, then drain in order
    out_ready = 0; n_acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; in_data = W'(32'hA1 + n_acc);
      #1;
      chk("stall_occ", W'(occupancy), W'(exp_occ[c]));
      chk("stall_rdy", W'(in_ready), W'(exp_rdy[c]));
      if (in_ready) n_acc++;
      step();
    end
    out_ready = 1; n_out = 0;
    for (int c = 0; c < 20; c++) begin
      if (n_acc < 4) begin
        in_valid = 1; in_data = W'(32'hA1 + n_acc);
      end else begin
        in_valid = 0;
      end
      #1;
      if (out_valid) begin
        chk("drain_data", out_data, W'(32'hA1 + n_out));
        n_out++;
      end
      if (in_valid && in_ready) n_acc++;
      step();
    end
    chk("drain_cnt", W'(n_out), W'(4));

    // flush while holding two beats
    out_ready = 0;
    in_valid = 1; in_data = W'(32'hB1);
    #1;
    chk("fl_fill1", W'(in_ready), W'(1));
    step();
    in_data = W'(32'hB2);
    #1;
    chk("fl_fill2", W'(in_ready), W'(1));
    step();
    flush = 1; in_data = W'(32'hB3);
    #1;
    chk("fl_occ_before", W'(occupancy), W'(2));
    chk("fl_rdy", W'(in_ready), W'(0));
    step();
    flush = 0; in_valid = 0;
    #1;
    chk("fl_occ", W'(occupancy), W'(0));
    chk("fl_vld", W'(out_valid), W'(0));
    chk("fl_data_kept", out_data, W'(32'hB1));
    out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("fl_noacc", W'(out_valid), W'(0));
    end

    // reset asserted mid-stream
    for (int c = 0; c < 3; c++) begin
      in_valid = 1; in_data = W'(32'hC1 + c);
      step();
    end
    in_valid = 0;
    reset_n = 0;
    #1;
    chk("mrst_data", out_data, RV);
    chk("mrst_vld", W'(out_valid), W'(0));
    chk("mrst_occ", W'(occupancy), W'(0));
    chk("mrst_rdy", W'(in_ready), W'(0));
    step();
    reset_n = 1;
    step();
    step();
    chk("mrst_nopart_vld", W'(out_valid), W'(0));
    chk("mrst_nopart_occ", W'(occupancy), W'(0));

    // random stress with scoreboard
    q = {};
    for (int c = 0; c < 10000; c++) begin
      chk("rnd_occ", W'(occupancy), W'(q.size()));
      in_valid = ($urandom % 4) != 0;
      in_clear = 1'($urandom % 2);
      for (int j = 0; j < 8; j++) in_data[j*32 +: 32] = $urandom;
      out_ready = ($urandom % 3) != 0;
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", W'(out_valid), W'(0));
        end else begin
          exp_d = q.pop_front();
          chk("rnd_data", out_data, exp_d);
        end
      end
      if (in_valid && in_ready) q.push_back(in_clear ? (in_data ^ MK) : in_data);
      step();
    end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", W'(out_valid), W'(0));
        end else begin
          exp_d = q.pop_front();
          chk("rnd_data", out_data, exp_d);
        end
      end
      step();
    end
    chk("rnd_left", W'(q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
